// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch front end: issues sequential fetches, buffers {pc, inst} pairs in order,
// and flushes on redirect while discarding wrong-path responses still in flight.
module inst_prefetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] PC,
    output logic              Inst_Req_Valid,
    input  logic              Inst_Req_Ready,
    input  logic [DATA_W-1:0] Instruction,
    input  logic              Inst_Valid,
    output logic              Inst_Ready,
    output logic [DATA_W-1:0] core_inst,
    output logic [ADDR_W-1:0] core_pc,
    output logic              core_valid,
    input  logic              core_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       fetch_req_cnt,
    output logic [31:0]       flush_drop_cnt
);

    localparam int unsigned       PW        = $clog2(DEPTH);
    localparam int unsigned       CW        = PW + 1;
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
    localparam logic [CW:0]       DEPTH_OCC = (CW+1)'(DEPTH);

    logic              running_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              redir_pend_q, redir_pend_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;

    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_inst [DEPTH];

    logic [CW:0] occupancy;
    logic        req_hs, req_stall, rsp_fire, rsp_drop, push, pop;

    // Space for every in-flight response is reserved up front, so occupancy can
    // only grow on a handshake and a raised request never falls before acceptance.
    assign occupancy      = {1'b0, count_q} + {1'b0, inflight_q};
    assign Inst_Req_Valid = running_q && (occupancy < DEPTH_OCC);
    assign Inst_Ready     = running_q;
    assign req_hs         = Inst_Req_Valid && Inst_Req_Ready;
    assign req_stall      = Inst_Req_Valid && !Inst_Req_Ready;
    assign rsp_fire       = Inst_Valid && running_q;
    assign rsp_drop       = rsp_fire && ((drop_q != '0) || redirect_valid);
    assign push           = rsp_fire && !rsp_drop;
    assign pop            = core_valid && core_ready && !redirect_valid;

    assign PC             = pc_q;
    assign core_valid     = (count_q != '0);
    assign core_pc        = mem_pc[rd_ptr_q];
    assign core_inst      = mem_inst[rd_ptr_q];
    assign fetch_req_cnt  = fetch_cnt_q;
    assign flush_drop_cnt = drop_cnt_q;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        tgt_d        = tgt_q;
        redir_pend_d = redir_pend_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_d       = drop_q;
        inflight_d   = inflight_q + CW'(req_hs) - CW'(rsp_fire);
        fetch_cnt_d  = fetch_cnt_q + 32'(req_hs);
        drop_cnt_d   = drop_cnt_q + 32'(rsp_drop);

        if (redirect_valid) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            resp_pc_d = redirect_pc;
            drop_d    = inflight_d;
            if (req_stall) begin
                // The stalled address must stay on the bus; swap it in once accepted.
                redir_pend_d = 1'b1;
                tgt_d        = redirect_pc;
            end else begin
                redir_pend_d = 1'b0;
                pc_d         = redirect_pc;
            end
        end else begin
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                resp_pc_d = resp_pc_q + PC_STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (rsp_fire && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (req_hs) begin
                if (redir_pend_q) begin
                    drop_d       = drop_d + CW'(1);
                    pc_d         = tgt_q;
                    redir_pend_d = 1'b0;
                end else begin
                    pc_d = pc_q + PC_STEP;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments with reset sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            running_q    <= 1'b0;
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            tgt_q        <= RESET_PC;
            redir_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            drop_q       <= '0;
            fetch_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            running_q    <= 1'b1;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            tgt_q        <= tgt_d;
            redir_pend_q <= redir_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            fetch_cnt_q  <= fetch_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // NOTE: the entry array has no reset; core_valid qualifies the head, so stale words are never used.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]   <= resp_pc_q;
            mem_inst[wr_ptr_q] <= Instruction;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Randomized bench for inst_prefetch_unit: a queue-based model of outstanding fetches
// (tagged right/wrong path) and the delivered stream predicts every output each cycle.
module tb_inst_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] core_inst;
    logic [31:0] core_pc;
    logic        core_valid;
    logic        core_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_req_cnt;
    logic [31:0] flush_drop_cnt;

    always #5 clk = ~clk;

    inst_prefetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .Inst_Req_Valid (Inst_Req_Valid),
        .Inst_Req_Ready (Inst_Req_Ready),
        .Instruction    (Instruction),
        .Inst_Valid     (Inst_Valid),
        .Inst_Ready     (Inst_Ready),
        .core_inst      (core_inst),
        .core_pc        (core_pc),
        .core_valid     (core_valid),
        .core_ready     (core_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_req_cnt  (fetch_req_cnt),
        .flush_drop_cnt (flush_drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, want);
        end
    endtask

    typedef struct { logic [31:0] pc; bit good; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        out_q[$];   // accepted requests awaiting a response, oldest first
    ent_t        fifo_q[$];  // pairs the core should see, head first
    logic [31:0] m_pc, m_tgt, m_fetch, m_drop;
    bit          m_next_bad, m_run;
    int          rst_hold;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        out_q.delete();
        fifo_q.delete();
        m_pc       = RESET_PC;
        m_tgt      = RESET_PC;
        m_fetch    = 0;
        m_drop     = 0;
        m_next_bad = 0;
        m_run      = 0;
    endtask

    task automatic run_phase(input int cycles, input int p_rdy, input int p_rsp,
                             input int p_core, input int p_redir, input int p_rst_pm);
        for (int c = 0; c < cycles; c++) begin
            bit   exp_rv, hs, rsp, stall;
            req_t r;

            @(negedge clk);
            if (rst_hold > 0) begin
                rst = 1'b0;
                rst_hold--;
            end else if ($urandom_range(999) < p_rst_pm) begin
                rst      = 1'b0;
                rst_hold = 1;
            end else begin
                rst = 1'b1;
            end
            Inst_Req_Ready = ($urandom_range(99) < p_rdy);
            core_ready     = ($urandom_range(99) < p_core);
            redirect_valid = ($urandom_range(99) < p_redir);
            redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            if (!rst || !m_run) begin
                // Junk responses while the unit is in or leaving reset must be ignored.
                Inst_Valid  = $urandom_range(1);
                Instruction = $urandom;
            end else if (out_q.size() > 0 && $urandom_range(99) < p_rsp) begin
                Inst_Valid  = 1'b1;
                Instruction = inst_of(out_q[0].pc);
            end else begin
                Inst_Valid  = 1'b0;
                Instruction = $urandom;
            end

            exp_rv = m_run && ((fifo_q.size() + out_q.size()) < DEPTH);
            check("req_valid", 32'(Inst_Req_Valid), 32'(exp_rv));
            check("pc", PC, m_pc);
            check("inst_ready", 32'(Inst_Ready), 32'(m_run));
            check("core_valid", 32'(core_valid), 32'(fifo_q.size() != 0));
            if (fifo_q.size() != 0) begin
                check("core_pc", core_pc, fifo_q[0].pc);
                check("core_inst", core_inst, fifo_q[0].inst);
            end
            check("fetch_req_cnt", fetch_req_cnt, m_fetch);
            check("flush_drop_cnt", flush_drop_cnt, m_drop);

            if (!rst) begin
                model_reset();
            end else begin
                hs    = exp_rv && Inst_Req_Ready;
                stall = exp_rv && !Inst_Req_Ready;
                rsp   = m_run && Inst_Valid;
                if (!redirect_valid && core_ready && fifo_q.size() != 0) begin
                    void'(fifo_q.pop_front());
                end
                if (rsp && out_q.size() != 0) begin
                    r = out_q.pop_front();
                    if (!r.good || redirect_valid) m_drop++;
                    else fifo_q.push_back('{pc: r.pc, inst: inst_of(r.pc)});
                end
                if (hs) begin
                    out_q.push_back('{pc: m_pc, good: !m_next_bad});
                    m_fetch++;
                    if (m_next_bad) begin
                        m_pc       = m_tgt;
                        m_next_bad = 0;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                end
                if (redirect_valid) begin
                    fifo_q.delete();
                    foreach (out_q[i]) out_q[i].good = 0;
                    if (stall) begin
                        m_next_bad = 1;
                        m_tgt      = redirect_pc;
                    end else begin
                        m_next_bad = 0;
                        m_pc       = redirect_pc;
                    end
                end
                m_run = 1;
            end
        end
    endtask

    initial begin
        rst            = 1'b0;
        Inst_Req_Ready = 1'b0;
        Instruction    = '0;
        Inst_Valid     = 1'b0;
        core_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        rst_hold = 1;

        // Streaming: memory always ready with single-cycle responses, core always accepting.
        run_phase(40, 100, 100, 100, 0, 0);
        // Core stalled: fill to DEPTH and stop requesting, then drain and resume.
        run_phase(30, 100, 100, 0, 0, 0);
        run_phase(30, 100, 100, 100, 0, 0);
        // Redirects with several fetches in flight.
        run_phase(300, 70, 60, 70, 8, 0);
        // Slow memory so redirects often land on a stalled request, including back-to-back.
        run_phase(300, 20, 50, 50, 20, 0);
        // Near-full buffer with simultaneous push and pop, plus occasional redirects.
        run_phase(300, 100, 100, 50, 5, 0);
        // Resets dropped into live traffic.
        run_phase(400, 60, 60, 60, 5, 20);
        // Mixed traffic.
        run_phase(2000, 60, 55, 65, 6, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
